// File: rtl/i2c_pkg.sv
// i2c_pkg: command codes, FSM states and FIFO entry width shared by the I2C command master.
package i2c_pkg;
  localparam logic [1:0] k_START_CMD = 2'd0;
  localparam logic [1:0] k_STOP_CMD = 2'd1;
  localparam logic [1:0] k_WRITE_CMD = 2'd2;
  localparam logic [1:0] k_READ_CMD = 2'd3;
  localparam int k_ENTRY_W = 10;
  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_ACK, S_DONE} state_t;
  function automatic state_t cmd_state(input logic [1:0] c);
    return c == k_START_CMD ? S_START : c == k_STOP_CMD ? S_STOP : S_BIT;
  endfunction
endpackage

// File: rtl/i2c_cmd_if.sv
// i2c_cmd_if: host command port plus open-drain pad controls of the I2C command master.
interface i2c_cmd_if;
  logic write;
  logic [1:0] cmd;
  logic [7:0] data_in;
  logic ready;
  logic busy;
  logic [7:0] rd_data;
  logic rd_valid;
  logic ack_err;
  logic scl_oe;
  logic sda_oe;
  logic scl_i;
  logic sda_i;
  modport master (output write, cmd, data_in, scl_i, sda_i,
                  input ready, busy, rd_data, rd_valid, ack_err, scl_oe, sda_oe);
  modport slave (input write, cmd, data_in, scl_i, sda_i,
                 output ready, busy, rd_data, rd_valid, ack_err, scl_oe, sda_oe);
endinterface

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = k_ENTRY_W
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: command-queued I2C bit/byte engine on open-drain SCL/SDA.
// Optional feature: define I2C_CLOCK_STRETCH_EN to let a slave stretch SCL.
module i2c_cmd_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  i2c_cmd_if.slave bus
);
  localparam int TW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  state_t state, state_nx;
  logic [TW-1:0] tick;
  logic [1:0] qtr;
  logic [2:0] bit_cnt;
  logic [1:0] cur_cmd;
  logic [7:0] d, rx;
  logic [k_ENTRY_W-1:0] head;
  logic scl_hold, full, empty, push, pop, stall, q_end, cell_end, sample;
  assign push = bus.write && !full;
  assign bus.ready = !full;
  assign bus.busy = state != S_IDLE || !empty;
  i2c_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(k_ENTRY_W)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din({bus.cmd, bus.data_in}), .dout(head), .full(full), .empty(empty)
  );
`ifdef I2C_CLOCK_STRETCH_EN
  assign stall = !bus.scl_i && ((((state == S_BIT) || (state == S_ACK)) && qtr == 2'd2) ||
                                (state == S_STOP && qtr == 2'd1));
`else
  assign stall = 1'b0;
`endif
  assign q_end = !stall && tick == TW'(CLK_DIV - 1);
  assign cell_end = q_end && qtr == 2'd3;
  assign sample = (state == S_BIT || state == S_ACK) && qtr == 2'd3 && tick == '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    bus.scl_oe = scl_hold;
    bus.sda_oe = 1'b0;
    bus.rd_valid = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        pop = !empty;
        bus.rd_valid = state == S_DONE && cur_cmd == k_READ_CMD;
        state_nx = empty ? S_IDLE : cmd_state(head[9:8]);
      end
      S_START: begin
        bus.scl_oe = qtr == 2'd3;
        bus.sda_oe = qtr[1];
        if (cell_end) state_nx = S_DONE;
      end
      S_STOP: begin
        bus.scl_oe = qtr == 2'd0;
        bus.sda_oe = qtr != 2'd3;
        if (cell_end) state_nx = S_DONE;
      end
      S_BIT: begin
        bus.scl_oe = !qtr[1];
        bus.sda_oe = cur_cmd == k_WRITE_CMD && !d[3'd7 - bit_cnt];
        if (cell_end && bit_cnt == 3'd7) state_nx = S_ACK;
      end
      S_ACK: begin
        bus.scl_oe = !qtr[1];
        bus.sda_oe = cur_cmd == k_READ_CMD && !d[0];
        if (cell_end) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // Quarter/tick pacing and the byte datapath; a pop restarts pacing for the new command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
      qtr <= '0;
      bit_cnt <= '0;
      cur_cmd <= '0;
      d <= '0;
      rx <= '0;
      scl_hold <= 1'b0;
      bus.rd_data <= '0;
      bus.ack_err <= 1'b0;
    end else if (pop) begin
      tick <= '0;
      qtr <= '0;
      bit_cnt <= '0;
      {cur_cmd, d} <= head;
      if (head[9:8] == k_START_CMD) bus.ack_err <= 1'b0;
    end else if (state != S_IDLE && state != S_DONE) begin
      if (!stall) tick <= q_end ? '0 : tick + 1'b1;
      if (q_end) qtr <= qtr + 1'b1;
      if (cell_end && state == S_BIT) bit_cnt <= bit_cnt + 1'b1;
      if (sample && state == S_BIT) rx <= {rx[6:0], bus.sda_i};
      if (sample && state == S_ACK && cur_cmd == k_WRITE_CMD && bus.sda_i) bus.ack_err <= 1'b1;
      if (cell_end && state == S_ACK && cur_cmd == k_READ_CMD) bus.rd_data <= rx;
      if (cell_end) scl_hold <= state != S_STOP;
    end
  end
endmodule

// File: tb/tb_i2c_cmd_master.sv
// tb_i2c_cmd_master: random and directed stimulus checked every cycle against a per-clock waveform model.
module tb_i2c_cmd_master;
  import i2c_pkg::*;
  localparam int CD = 2;
  typedef struct packed {
    logic scl;
    logic sda;
    logic rv;
    logic sin;
    logic seterr;
    logic ldrd;
    logic [7:0] rdv;
  } ent_t;
  logic clk, reset;
  i2c_cmd_if bus();
  i2c_cmd_master #(.CLK_DIV(CD), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0, fails = 0, rel_cnt = 0, nack_mode = 0;
  logic rd_fixed_en = 1'b0;
  logic [7:0] rd_fixed = 8'h00;
  logic [9:0] q[$];
  ent_t wave[$];
  logic hold = 1'b0, m_err = 1'b0, prev_scl = 1'b0;
  logic [7:0] m_rd = 8'h00;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add_cell(input logic [3:0] scl_q, input logic [3:0] sda_q, input logic sin);
    for (int k = 0; k < 4; k++)
      for (int t = 0; t < CD; t++) begin
        ent_t e;
        e = '0;
        e.scl = scl_q[k];
        e.sda = sda_q[k];
        e.sin = sin;
        wave.push_back(e);
      end
  endtask
  // Expected per-clock outputs of one command, built from the quarter tables of each cell.
  task automatic start_cmd(input logic [1:0] c, input logic [7:0] dv);
    logic nack;
    logic [7:0] rb;
    int base;
    ent_t e;
    base = 0;
    nack = nack_mode == 2 ? 1'($urandom_range(0, 1)) : nack_mode == 1;
    rb = rd_fixed_en ? rd_fixed : 8'($urandom);
    if (c == k_START_CMD) begin
      add_cell(4'b1000, 4'b1100, 1'b1);
      m_err = 1'b0;
    end else if (c == k_STOP_CMD) add_cell(4'b0001, 4'b0111, 1'b1);
    else begin
      for (int b = 7; b >= 0; b--)
        add_cell(4'b0011, {4{c == k_WRITE_CMD && !dv[b]}}, c == k_READ_CMD ? rb[b] : 1'b1);
      base = wave.size();
      add_cell(4'b0011, {4{c == k_READ_CMD && !dv[0]}}, c == k_WRITE_CMD ? nack : 1'b1);
    end
    hold = c != k_STOP_CMD;
    e = '0;
    e.scl = hold;
    e.sin = 1'b1;
    e.rv = c == k_READ_CMD;
    e.ldrd = c == k_READ_CMD;
    e.rdv = rb;
    wave.push_back(e);
    if (c == k_WRITE_CMD && nack) begin
      e = wave[base + 3 * CD + 1];
      e.seterr = 1'b1;
      wave[base + 3 * CD + 1] = e;
    end
  endtask
  always @(posedge clk or negedge reset) begin
    int qs;
    logic free;
    logic [9:0] c;
    if (!reset) begin
      q.delete();
      wave.delete();
      hold = 1'b0;
      m_err = 1'b0;
      m_rd = 8'h00;
    end else begin
      free = wave.size() <= 1;
      qs = q.size();
      if (wave.size() > 0) void'(wave.pop_front());
      if (free && qs > 0) begin
        c = q.pop_front();
        start_cmd(c[9:8], c[7:0]);
      end
      if (bus.write && qs < 4) q.push_back({bus.cmd, bus.data_in});
      if (wave.size() > 0) begin
        if (wave[0].seterr) m_err = 1'b1;
        if (wave[0].ldrd) m_rd = wave[0].rdv;
      end
    end
  end
  always @(negedge clk) begin
    ent_t e;
    if (reset) begin
      if (wave.size() > 0) e = wave[0];
      else begin
        e = '0;
        e.scl = hold;
        e.sin = 1'b1;
      end
      chk("scl_oe", bus.scl_oe, e.scl);
      chk("sda_oe", bus.sda_oe, e.sda);
      chk("rd_valid", bus.rd_valid, e.rv);
      chk("busy", bus.busy, wave.size() > 0 || q.size() > 0);
      chk("ready", bus.ready, q.size() < 4);
      chk("ack_err", bus.ack_err, m_err);
      chk("rd_data", bus.rd_data, m_rd);
      bus.sda_i = e.sin;
      if (prev_scl && !bus.scl_oe) rel_cnt++;
    end else bus.sda_i = 1'b1;
    prev_scl = bus.scl_oe;
  end
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic push(input logic [1:0] c, input logic [7:0] dv);
    @(negedge clk);
    bus.write = 1'b1;
    bus.cmd = c;
    bus.data_in = dv;
    @(negedge clk);
    bus.write = 1'b0;
  endtask
  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    while (bus.busy && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("idle_wait", bus.busy, 0);
  endtask
  initial begin
    logic [7:0] obs;
    int rv_cnt;
    logic ack_sda;
    logic [7:0] rv_data;
    bus.write = 1'b0;
    bus.cmd = '0;
    bus.data_in = '0;
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    chk("rst_scl", bus.scl_oe, 0);
    chk("rst_sda", bus.sda_oe, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    push(k_START_CMD, 8'h00);
    step(4);
    chk("start_sda_q1", bus.sda_oe, 0);
    step(1);
    chk("start_sda_rise", bus.sda_oe, 1);
    chk("start_scl_q2", bus.scl_oe, 0);
    step(1);
    chk("start_scl_pre", bus.scl_oe, 0);
    step(1);
    chk("start_scl_rise", bus.scl_oe, 1);
    step(2);
    chk("start_busy9", bus.busy, 1);
    step(1);
    chk("start_busy10", bus.busy, 0);
    push(k_WRITE_CMD, 8'hA5);
    step(2);
    for (int k = 0; k < 8; k++) begin
      obs[7-k] = bus.sda_oe;
      step(8);
    end
    chk("wr_bits", obs, 8'h5A);
    chk("wr_ack_sda", bus.sda_oe, 0);
    chk("wr_ack_scl", bus.scl_oe, 1);
    step(7);
    chk("wr_busy73", bus.busy, 1);
    step(1);
    chk("wr_busy74", bus.busy, 0);
    chk("wr_ack_ok", bus.ack_err, 0);
    nack_mode = 1;
    push(k_WRITE_CMD, 8'h00);
    wait_idle(200);
    chk("nack_set", bus.ack_err, 1);
    nack_mode = 0;
    push(k_STOP_CMD, 8'h00);
    wait_idle(200);
    chk("nack_after_stop", bus.ack_err, 1);
    chk("stop_scl_rel", bus.scl_oe, 0);
    chk("stop_sda_rel", bus.sda_oe, 0);
    push(k_START_CMD, 8'h00);
    chk("nack_before_pop", bus.ack_err, 1);
    step(1);
    chk("nack_clr_start", bus.ack_err, 0);
    wait_idle(200);
    rd_fixed_en = 1'b1;
    rd_fixed = 8'h3C;
    push(k_READ_CMD, 8'h01);
    rv_cnt = 0;
    ack_sda = 1'b0;
    rv_data = 8'h00;
    for (int n = 1; n <= 80; n++) begin
      step(1);
      if (bus.rd_valid) begin
        rv_cnt++;
        rv_data = bus.rd_data;
      end
      if (n >= 65 && n <= 72) ack_sda = ack_sda | bus.sda_oe;
    end
    chk("rd_valid_cnt", rv_cnt, 1);
    chk("rd_byte", rv_data, 8'h3C);
    chk("rd_nack_sda", ack_sda, 0);
    rd_fixed_en = 1'b0;
    wait_idle(200);
    @(posedge clk);
    rel_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.write = 1'b1;
      bus.cmd = k_WRITE_CMD;
      bus.data_in = 8'($urandom);
      @(negedge clk);
      if (i == 3) chk("burst_ready4", bus.ready, 1);
      if (i == 4) chk("burst_ready5", bus.ready, 0);
    end
    bus.write = 1'b0;
    wait_idle(1000);
    chk("burst_cells", rel_cnt, 45);
    push(k_WRITE_CMD, 8'h00);
    step(18);
    chk("pre_rst_scl", bus.scl_oe, 1);
    chk("pre_rst_sda", bus.sda_oe, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_scl", bus.scl_oe, 0);
    chk("mid_rst_sda", bus.sda_oe, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.ready, 1);
    @(negedge clk);
    reset = 1'b1;
    nack_mode = 2;
    for (int i = 0; i < 60; i++) begin
      push(2'($urandom_range(0, 3)), 8'($urandom));
      step($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) wait_idle(1000);
    end
    wait_idle(6000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
